// File: rtl/hls_fp17_add_pkg.sv
// Shared fp17 adder definitions.
// Reused by the core and the channel holding stages.
package hls_fp17_add_pkg;

    localparam int FP17_W = 17;
    localparam int OCC_W  = 2;
    localparam int DEPTH  = 2;

    typedef logic [FP17_W-1:0] fp17_t;
    typedef logic [OCC_W-1:0]  occ_t;

endpackage

// File: rtl/hls_fp17_add_chn_o_skid_if.sv
// chn_o skid stage bundle: core-side handshake, downstream handshake,
// and debug observability.
interface hls_fp17_add_chn_o_skid_if
    import hls_fp17_add_pkg::*;
#(
    parameter int WIDTH = FP17_W,
    parameter int CNT_W = 16
);
    logic             core_vld;
    logic [WIDTH-1:0] core_pd;
    logic             core_rdy;
    logic             chn_o_lz;
    logic [WIDTH-1:0] chn_o_z;
    logic             chn_o_vz;
    occ_t             occ;
    logic             pend;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_clr;

    modport master (
        input  core_vld, core_pd, chn_o_vz, stall_clr,
        output core_rdy, chn_o_lz, chn_o_z, occ, pend, stall_cnt
    );

    modport slave (
        output core_vld, core_pd, chn_o_vz, stall_clr,
        input  core_rdy, chn_o_lz, chn_o_z, occ, pend, stall_cnt
    );

endinterface

// File: rtl/hls_fp17_add_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module hls_fp17_add_sat_cnt #(
    parameter int W = 16
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hls_fp17_add_chn_o_skid.sv
// Two-entry registered skid buffer on the fp17 adder chn_o port,
// with occupancy, pending flag and stall counter for debug.
module hls_fp17_add_chn_o_skid
    import hls_fp17_add_pkg::*;
#(
    parameter int WIDTH = FP17_W,
    parameter int CNT_W = 16
) (
    input  logic                              nvdla_core_clk,
    input  logic                              nvdla_core_rstn,
    hls_fp17_add_chn_o_skid_if.master         bus
);

    occ_t             cnt;
    occ_t             cnt_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             rdy;
    logic             pend;
    logic             push;
    logic             pop;
    logic             lz;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    assign lz    = (cnt != 2'd0);
    assign push  = bus.core_vld & rdy;
    assign pop   = lz & bus.chn_o_vz;
    assign stall = lz & ~bus.chn_o_vz;

    always_comb begin
        cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    end

    // Ready is registered from next occupancy so it never sees chn_o_vz.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
            rdy  <= 1'b1;
            pend <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            rdy <= (cnt_nxt <= 2'd1);
            if (stall) begin
                pend <= 1'b1;
            end else if (pop || (cnt_nxt == 2'd0)) begin
                pend <= 1'b0;
            end
            unique case (1'b1)
                (cnt == 2'd0): begin
                    if (push) head <= bus.core_pd;
                end
                (cnt == 2'd1): begin
                    if (push && pop) head <= bus.core_pd;
                    else if (push)   tail <= bus.core_pd;
                end
                (cnt == 2'd2): begin
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= bus.core_pd;
                    end
                end
                default: ;
            endcase
        end
    end

    hls_fp17_add_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .inc             (stall),
        .clr             (bus.stall_clr),
        .cnt             (stall_cnt)
    );

    assign bus.core_rdy  = rdy;
    assign bus.chn_o_lz  = lz;
    assign bus.chn_o_z   = head;
    assign bus.occ       = cnt;
    assign bus.pend      = pend;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hls_fp17_add_chn_o_skid.sv
// Bench for the chn_o skid stage: directed scenarios plus random
// handshakes, checked against a queue-based reference model.
module tb_hls_fp17_add_chn_o_skid;
    import hls_fp17_add_pkg::*;

    localparam int WIDTH = FP17_W;
    localparam int CNT_W = 16;

    logic nvdla_core_clk;
    logic nvdla_core_rstn;

    hls_fp17_add_chn_o_skid_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    hls_fp17_add_chn_o_skid #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .bus             (bus)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int n_vec;
    int n_err;

    // Reference model: FIFO contents as a queue of results.
    logic [WIDTH-1:0] q[$];
    logic             m_rdy;
    logic             m_pend;
    int               m_stall;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy   = 1'b1;
        m_pend  = 1'b0;
        m_stall = 0;
    endtask

    task automatic check_all();
        chk("occ", 32'(bus.occ), 32'(q.size()));
        chk("lz", 32'(bus.chn_o_lz), 32'(q.size() != 0));
        chk("rdy", 32'(bus.core_rdy), 32'(m_rdy));
        chk("pend", 32'(bus.pend), 32'(m_pend));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        if (q.size() != 0)
            chk("chn_o_z", 32'(bus.chn_o_z), 32'(q[0]));
        chk("occ_le2", 32'(bus.occ <= 2'd2), 32'd1);
    endtask

    // One clock: drive at negedge, update model at posedge, check next negedge.
    task automatic cycle(input logic vld, input logic [WIDTH-1:0] pd,
                         input logic vz, input logic clr);
        logic push, pop, stl;
        bus.core_vld  = vld;
        bus.core_pd   = pd;
        bus.chn_o_vz  = vz;
        bus.stall_clr = clr;
        push = vld && m_rdy;
        pop  = (q.size() != 0) && vz;
        stl  = (q.size() != 0) && !vz;
        @(posedge nvdla_core_clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(pd);
        m_rdy  = (q.size() <= 1);
        m_pend = stl;
        if (clr)                 m_stall = 0;
        else if (stl && m_stall < 65535) m_stall++;
        @(negedge nvdla_core_clk);
        check_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.core_vld  = 1'b0;
        bus.core_pd   = '0;
        bus.chn_o_vz  = 1'b0;
        bus.stall_clr = 1'b0;
        nvdla_core_rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge nvdla_core_clk);
        chk("rst_z", 32'(bus.chn_o_z), 32'd0);
        check_all();
        nvdla_core_rstn = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Streaming at full rate
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
            chk("stream_z", 32'(bus.chn_o_z), 32'(i));
            chk("stream_occ", 32'(bus.occ <= 2'd1), 32'd1);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stream_drain", 32'(bus.occ), 32'd0);

        // Back-pressure, then simultaneous pop with ready dropping
        cycle(1'b1, 17'h1ABCD, 1'b0, 1'b0);
        cycle(1'b1, 17'h00123, 1'b0, 1'b0);
        chk("bp_occ", 32'(bus.occ), 32'd2);
        chk("bp_rdy", 32'(bus.core_rdy), 32'd0);
        chk("bp_pend", 32'(bus.pend), 32'd1);
        cycle(1'b1, 17'h0DEAD, 1'b0, 1'b0);
        chk("bp_hold", 32'(bus.chn_o_z), 32'h1ABCD);
        cycle(1'b1, 17'h0BEEF, 1'b1, 1'b0);
        chk("bp_pop1", 32'(bus.chn_o_z), 32'h00123);
        chk("bp_nopush", 32'(bus.occ), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", 32'(bus.occ), 32'd0);

        // Stall counter: count, clear, saturate
        cycle(1'b1, 17'h00077, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("stall5", 32'(bus.stall_cnt), 32'd5);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("stall_clr", 32'(bus.stall_cnt), 32'd0);
        for (int i = 0; i < 65539; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("stall_sat", 32'(bus.stall_cnt), 32'h0000FFFF);
        cycle(1'b0, '0, 1'b1, 1'b1);

        // Reset mid-stream with two entries held
        cycle(1'b1, 17'h12345, 1'b0, 1'b0);
        cycle(1'b1, 17'h06789, 1'b0, 1'b0);
        chk("pre_rst_occ", 32'(bus.occ), 32'd2);
        #2 nvdla_core_rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_occ", 32'(bus.occ), 32'd0);
        chk("rst_lz", 32'(bus.chn_o_lz), 32'd0);
        chk("rst_rdy", 32'(bus.core_rdy), 32'd1);
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        @(negedge nvdla_core_clk);
        check_all();
        nvdla_core_rstn = 1'b1;

        // Random handshakes
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  WIDTH'($urandom),
                  1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hls_fp17_add_chn_o_skid.md
# hls_fp17_add_chn_o_skid

Output-channel holding stage for the fp17 adder; sits directly downstream of the core's chn_o wait/handshake logic and drives the external chn_o interface. It captures each 17-bit result the core commits and buffers up to two results in a registered skid FIFO, so the core sees a registered ready and downstream back-pressure never forms a combinational path. It also exposes occupancy and a saturating back-pressure cycle counter for debug.

## Interface
- WIDTH, 17: payload width (fp17 result).
- CNT_W, 16: width of stall counter.
- nvdla_core_clk  in  1  clock; all state on rising edge.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- core_vld  in  1  core presents a result this cycle.
- core_pd  in  WIDTH  result payload.
- core_rdy  out  1  registered ready to core; transfer = core_vld & core_rdy.
- chn_o_lz  out  1  valid to downstream.
- chn_o_z  out  WIDTH  payload to downstream (registered, head entry).
- chn_o_vz  in  1  downstream ready; transfer = chn_o_lz & chn_o_vz.
- occ  out  2  current entry count, 0..2.
- pend  out  1  head entry valid and not accepted last cycle (held ≥1 cycle).
- stall_cnt  out  CNT_W  saturating count of cycles with chn_o_lz & !chn_o_vz.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Storage: two WIDTH-bit entries, head and tail, count register cnt[1:0].
- push = core_vld & core_rdy; pop = chn_o_lz & chn_o_vz.
- cnt next = cnt + push − pop; push and pop in same cycle legal at cnt 1 or 2 (cnt unchanged; at cnt 1 the new data replaces head).
- Write placement: cnt 0 → head; cnt 1 without pop → tail; cnt 1 with pop → head; cnt 2 with pop → tail after tail→head shift.
- Pop with cnt 2 shifts tail to head.
- core_rdy next = (cnt next ≤ 1). Overflow impossible: push only when core_rdy high.
- chn_o_lz = (cnt != 0); chn_o_z = head; occ = cnt.
- pend set when chn_o_lz & !chn_o_vz; cleared on pop or when cnt becomes 0.
- stall_cnt: +1 per stall cycle, saturates at all-ones; stall_clr has priority over increment.
- No data-dependent processing; payload bits pass unmodified.

## Timing
- Reset values: cnt 0, chn_o_lz 0, chn_o_z 0, core_rdy 1, occ 0, pend 0, stall_cnt 0; entries cleared.
- Latency: result pushed in cycle N is visible on chn_o_z/chn_o_lz in cycle N+1 (cnt was 0). No combinational path core_* → chn_o_* or chn_o_vz → core_rdy.
- Throughput: 1 result/cycle when chn_o_vz held high.
- Full (cnt 2): core_rdy low next cycle; rises the cycle after first pop.
- Empty: chn_o_lz low; chn_o_vz ignored, no pop.
- chn_o_z stable while chn_o_lz & !chn_o_vz (AXI-style hold).
- Reset mid-transfer: buffered results discarded; outputs return to reset values asynchronously.

## Structure
- Shared package hls_fp17_add_pkg: FP17_W = 17 and typedef fp17_t; reused by core and channel blocks.
- Optional sub-module hls_fp17_add_sat_cnt (parameterised saturating counter with clear) for stall_cnt; storage/control inline.

## Test plan
- Reset: assert rstn low mid-stream with cnt 2 → next cycle occ 0, chn_o_lz 0, core_rdy 1, stall_cnt 0.
- Streaming: core_vld high with 0x00001..0x00010, chn_o_vz high → same 16 values out in order, one per cycle, 1-cycle latency, occ ≤ 1.
- Back-pressure: chn_o_vz low, push 0x1ABCD, 0x00123 → occ 2, core_rdy low from next cycle, chn_o_z holds 0x1ABCD, pend 1; release vz → 0x1ABCD then 0x00123.
- Simultaneous push/pop at cnt 2: pop 0x1ABCD while core_rdy drops → no third push; order preserved, no loss or duplicate.
- Stall counter: 5 stall cycles → stall_cnt 5; stall_clr during stall → 0 next cycle; force 2^16+3 stall cycles → saturates at 0xFFFF.
- Random vld/vz (10k cycles) vs scoreboard: in-order, lossless, chn_o_z stable under stall, cnt never > 2.
